// File: rtl/mod_updown_counter_if.sv
// Control and status bundle for mod_updown_counter.
// The master drives the controls and limit; the slave (the counter) returns count and flags.
interface mod_updown_counter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             stop;
    logic             en;
    logic             up_dn;
    logic             oneshot;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             busy;
    logic             done;

    modport master (
        output start, stop, en, up_dn, oneshot, load, load_val, limit,
        input  count, tc, wrap, busy, done
    );

    modport slave (
        input  start, stop, en, up_dn, oneshot, load, load_val, limit,
        output count, tc, wrap, busy, done
    );
endinterface

// File: rtl/mod_updown_counter.sv
// Modulo (0..limit) up/down counter with IDLE/RUN/DONE control FSM and one-shot mode.
// Define MOD_UPDOWN_COUNTER_DOWN_EN to make up_dn functional; otherwise the counter is up-only.
module mod_updown_counter #(
    parameter int unsigned WIDTH        = 8,
    parameter bit          RUN_ON_RESET = 1'b0
) (
    input logic                 clk,
    input logic                 reset,
    mod_updown_counter_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam state_e ResetState = RUN_ON_RESET ? StRun : StIdle;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;

    logic             dir_up;
    logic             at_top;
    logic             at_zero;
    logic [WIDTH-1:0] load_clamped;

`ifdef MOD_UPDOWN_COUNTER_DOWN_EN
    assign dir_up = bus.up_dn;
`else
    logic unused_up_dn;
    assign unused_up_dn = bus.up_dn;
    assign dir_up       = 1'b1;
`endif

    // at_top also covers count above a lowered limit
    assign at_top       = (count_q >= bus.limit);
    assign at_zero      = (count_q == '0);
    assign load_clamped = (bus.load_val > bus.limit) ? bus.limit : bus.load_val;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wrap_d  = 1'b0;
        if (bus.stop) begin
            state_d = StIdle;
        end else if (bus.start) begin
            count_d = dir_up ? '0 : bus.limit;
            state_d = StRun;
        end else if (bus.load) begin
            count_d = load_clamped;
        end else if ((state_q == StRun) && bus.en) begin
            if (dir_up) begin
                if (at_top) begin
                    wrap_d = 1'b1;
                    if (bus.oneshot) begin
                        count_d = bus.limit;
                        state_d = StDone;
                    end else begin
                        count_d = '0;
                    end
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    wrap_d = 1'b1;
                    if (bus.oneshot) begin
                        state_d = StDone;
                    end else begin
                        count_d = bus.limit;
                    end
                end else if (count_q > bus.limit) begin
                    // Out-of-range count snaps back into range without a wrap pulse
                    count_d = bus.limit;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ResetState;
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.count = count_q;
    assign bus.wrap  = wrap_q;
    assign bus.busy  = (state_q == StRun);
    assign bus.done  = (state_q == StDone);
    assign bus.tc    = dir_up ? at_top : at_zero;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench for mod_updown_counter (WIDTH=4): directed scenarios plus
// randomized traffic compared against a behavioural model.
module tb_mod_updown_counter;

    localparam int unsigned W = 4;
`ifdef MOD_UPDOWN_COUNTER_DOWN_EN
    localparam bit DownEn = 1'b1;
`else
    localparam bit DownEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mod_updown_counter_if #(.WIDTH(W)) bus ();

    mod_updown_counter #(
        .WIDTH       (W),
        .RUN_ON_RESET(1'b0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    int m_cnt;
    bit m_wrap;
    bit m_busy;
    bit m_done;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.en       = 1'b0;
        bus.up_dn    = 1'b1;
        bus.oneshot  = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = '0;
        bus.limit    = 4'd9;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_cnt  = 0;
        m_wrap = 1'b0;
        m_busy = 1'b0;
        m_done = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic do_load(input logic [3:0] v);
        bus.load     = 1'b1;
        bus.load_val = v;
        tick();
        bus.load     = 1'b0;
    endtask

    // Advance the model by one clock using the inputs about to be sampled.
    task automatic model_step();
        int lim = int'(bus.limit);
        bit up  = DownEn ? bus.up_dn : 1'b1;
        bit nw  = 1'b0;
        if (bus.stop) begin
            m_busy = 1'b0;
            m_done = 1'b0;
        end else if (bus.start) begin
            m_cnt  = up ? 0 : lim;
            m_busy = 1'b1;
            m_done = 1'b0;
        end else if (bus.load) begin
            m_cnt = (int'(bus.load_val) > lim) ? lim : int'(bus.load_val);
        end else if (m_busy && bus.en) begin
            if (up) begin
                if (m_cnt >= lim) begin
                    nw = 1'b1;
                    if (bus.oneshot) begin
                        m_cnt = lim; m_busy = 1'b0; m_done = 1'b1;
                    end else begin
                        m_cnt = 0;
                    end
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end else begin
                if (m_cnt == 0) begin
                    nw = 1'b1;
                    if (bus.oneshot) begin
                        m_busy = 1'b0; m_done = 1'b1;
                    end else begin
                        m_cnt = lim;
                    end
                end else if (m_cnt > lim) begin
                    m_cnt = lim;
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end
        end
        m_wrap = nw;
    endtask

    task automatic test_reset();
        logic [7:0] obs;
        idle_inputs();
        reset = 1'b1;
        #2;
        obs = {bus.count, bus.wrap, bus.busy, bus.done, bus.tc};
        n_tests++;
        if (obs !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_async: got %b expected %b", obs, 8'h00);
        end
        tick();
        reset = 1'b0;
        tick();
        obs = {bus.count, bus.wrap, bus.busy, bus.done, bus.tc};
        n_tests++;
        if (obs !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_idle_hold: got %b expected %b", obs, 8'h00);
        end
    endtask

    task automatic test_up_count();
        logic [7:0] obs, exp;
        logic [3:0] ec;
        idle_inputs();
        do_reset();
        bus.en = 1'b1;
        pulse_start();
        for (int i = 0; i < 12; i++) begin
            if (i > 0) tick();
            ec  = 4'(i % 10);
            exp = {ec, (i == 10), 1'b1, 1'b0, (ec == 4'd9)};
            obs = {bus.count, bus.wrap, bus.busy, bus.done, bus.tc};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL up_count[%0d]: got %b expected %b", i, obs, exp);
            end
        end
        bus.en = 1'b0;
    endtask

    task automatic test_oneshot();
        logic [7:0] obs, exp;
        logic [3:0] ec;
        logic [3:0] first = DownEn ? 4'd9 : 4'd0;
        logic [3:0] term  = DownEn ? 4'd0 : 4'd9;
        idle_inputs();
        do_reset();
        bus.oneshot = 1'b1;
        bus.up_dn   = DownEn ? 1'b0 : 1'b1;
        bus.en      = 1'b1;
        pulse_start();
        for (int i = 0; i < 13; i++) begin
            if (i > 0) tick();
            ec  = (i >= 9) ? term : (DownEn ? 4'(9 - i) : 4'(i));
            exp = {ec, (i == 10), (i < 10), (i >= 10), (ec == term)};
            obs = {bus.count, bus.wrap, bus.busy, bus.done, bus.tc};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL oneshot[%0d]: got %b expected %b", i, obs, exp);
            end
        end
        pulse_start();
        obs = {bus.count, bus.wrap, bus.busy, bus.done, 1'b0};
        exp = {first, 1'b0, 1'b1, 1'b0, 1'b0};
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL oneshot_restart: got %b expected %b", obs, exp);
        end
        idle_inputs();
    endtask

    task automatic test_load();
        logic [5:0] obs;
        idle_inputs();
        do_reset();
        pulse_start();
        do_load(4'd13);
        obs = {bus.count, bus.busy, bus.done};
        n_tests++;
        if (obs !== {4'd9, 2'b10}) begin
            n_fail++;
            $display("FAIL load_clamp: got %b expected %b", obs, {4'd9, 2'b10});
        end
        bus.start = 1'b1;
        do_load(4'd4);
        bus.start = 1'b0;
        obs = {bus.count, bus.busy, bus.done};
        n_tests++;
        if (obs !== {4'd0, 2'b10}) begin
            n_fail++;
            $display("FAIL load_vs_start: got %b expected %b", obs, {4'd0, 2'b10});
        end
        bus.en = 1'b1;
        do_load(4'd3);
        bus.en = 1'b0;
        obs = {bus.count, bus.busy, bus.done};
        n_tests++;
        if (obs !== {4'd3, 2'b10}) begin
            n_fail++;
            $display("FAIL load_vs_step: got %b expected %b", obs, {4'd3, 2'b10});
        end
        bus.stop = 1'b1;
        do_load(4'd7);
        bus.stop = 1'b0;
        obs = {bus.count, bus.busy, bus.done};
        n_tests++;
        if (obs !== {4'd3, 2'b00}) begin
            n_fail++;
            $display("FAIL load_vs_stop: got %b expected %b", obs, {4'd3, 2'b00});
        end
        do_load(4'd6);
        obs = {bus.count, bus.busy, bus.done};
        n_tests++;
        if (obs !== {4'd6, 2'b00}) begin
            n_fail++;
            $display("FAIL load_in_idle: got %b expected %b", obs, {4'd6, 2'b00});
        end
    endtask

    task automatic test_limit_lower();
        logic [4:0] obs;
        idle_inputs();
        do_reset();
        pulse_start();
        do_load(4'd7);
        bus.limit = 4'd5;
        #1;
        n_tests++;
        if (bus.tc !== 1'b1) begin
            n_fail++;
            $display("FAIL tc_above_limit: got %b expected 1", bus.tc);
        end
        bus.en = 1'b1;
        tick();
        bus.en = 1'b0;
        obs = {bus.count, bus.wrap};
        n_tests++;
        if (obs !== {4'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL limit_lower_up: got %b expected %b", obs, {4'd0, 1'b1});
        end
`ifdef MOD_UPDOWN_COUNTER_DOWN_EN
        bus.limit = 4'd9;
        do_load(4'd7);
        bus.limit = 4'd5;
        bus.up_dn = 1'b0;
        bus.en    = 1'b1;
        tick();
        bus.en    = 1'b0;
        obs = {bus.count, bus.wrap};
        n_tests++;
        if (obs !== {4'd5, 1'b0}) begin
            n_fail++;
            $display("FAIL limit_lower_down: got %b expected %b", obs, {4'd5, 1'b0});
        end
`endif
        idle_inputs();
    endtask

    task automatic test_start_stop();
        logic [6:0] obs;
        idle_inputs();
        do_reset();
        pulse_start();
        do_load(4'd6);
        bus.en    = 1'b1;
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.en    = 1'b0;
        obs = {bus.count, bus.wrap, bus.busy, bus.done};
        n_tests++;
        if (obs !== {4'd6, 3'b000}) begin
            n_fail++;
            $display("FAIL stop_beats_start: got %b expected %b", obs, {4'd6, 3'b000});
        end
        pulse_start();
        do_load(4'd6);
        bus.en = 1'b1;
        #3;
        reset = 1'b1;
        #1;
        obs = {bus.count, bus.wrap, bus.busy, bus.done};
        n_tests++;
        if (obs !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_mid_count: got %b expected %b", obs, 7'd0);
        end
        bus.en       = 1'b0;
        bus.load     = 1'b1;
        bus.load_val = 4'd5;
        tick();
        obs = {bus.count, bus.wrap, bus.busy, bus.done};
        n_tests++;
        if (obs !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_blocks_load: got %b expected %b", obs, 7'd0);
        end
        reset = 1'b0;
        tick();
        bus.load = 1'b0;
        obs = {bus.count, bus.wrap, bus.busy, bus.done};
        n_tests++;
        if (obs !== {4'd5, 3'b000}) begin
            n_fail++;
            $display("FAIL first_edge_after_reset: got %b expected %b", obs, {4'd5, 3'b000});
        end
    endtask

    task automatic test_direction();
        logic [4:0] obs, exp;
        idle_inputs();
        do_reset();
`ifdef MOD_UPDOWN_COUNTER_DOWN_EN
        bus.en = 1'b1;
        pulse_start();
        tick(); tick(); tick();
        bus.up_dn = 1'b0;
        tick();
        obs = {bus.count, bus.tc};
        exp = {4'd2, 1'b0};
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL dir_change_down: got %b expected %b", obs, exp);
        end
        bus.up_dn = 1'b1;
        tick();
        obs = {bus.count, bus.tc};
        exp = {4'd3, 1'b0};
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL dir_change_up: got %b expected %b", obs, exp);
        end
`else
        bus.up_dn = 1'b0;
        bus.en    = 1'b1;
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            obs = {bus.count, bus.tc};
            exp = {4'(i), 1'b0};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL up_dn_ignored[%0d]: got %b expected %b", i, obs, exp);
            end
        end
`endif
        idle_inputs();
    endtask

    task automatic test_limit_zero();
        logic [7:0] obs, exp;
        bit         e;
        idle_inputs();
        do_reset();
        bus.limit = 4'd0;
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            e      = 1'($urandom_range(0, 1));
            bus.en = e;
            tick();
            obs = {bus.count, bus.wrap, bus.busy, bus.done, bus.tc};
            exp = {4'd0, e, 1'b1, 1'b0, 1'b1};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL limit_zero[%0d]: got %b expected %b", i, obs, exp);
            end
        end
        bus.oneshot = 1'b1;
        bus.en      = 1'b1;
        tick();
        obs = {bus.count, bus.wrap, bus.busy, bus.done, bus.tc};
        exp = {4'd0, 1'b1, 1'b0, 1'b1, 1'b1};
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL limit_zero_oneshot: got %b expected %b", obs, exp);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [7:0] obs, exp;
        bit         up;
        for (int seg = 0; seg < 4; seg++) begin
            idle_inputs();
            bus.limit = 4'($urandom_range(0, 15));
            do_reset();
            for (int i = 0; i < 150; i++) begin
                bus.start    = ($urandom_range(0, 15) == 0);
                bus.stop     = ($urandom_range(0, 23) == 0);
                bus.load     = ($urandom_range(0, 9) == 0);
                bus.load_val = 4'($urandom_range(0, 15));
                bus.en       = ($urandom_range(0, 3) != 0);
                bus.up_dn    = 1'($urandom_range(0, 1));
                bus.oneshot  = (seg[0] == 1'b1) ? ($urandom_range(0, 3) != 0) : 1'b0;
                model_step();
                tick();
                up  = DownEn ? bus.up_dn : 1'b1;
                exp = {4'(m_cnt), m_wrap, m_busy, m_done,
                       up ? (m_cnt >= int'(bus.limit)) : (m_cnt == 0)};
                obs = {bus.count, bus.wrap, bus.busy, bus.done, bus.tc};
                n_tests++;
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL random[%0d/%0d]: got %b expected %b (limit %0d)",
                             seg, i, obs, exp, bus.limit);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_up_count();
        test_oneshot();
        test_load();
        test_limit_lower();
        test_start_stop();
        test_direction();
        test_limit_zero();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
